// File: rtl/mem_io_responder.sv
// Memory-mapped responder on the processor's external bus: RAM, LEDs,
// seven-segment digits, synchronised switches and an interval timer.
module mem_io_responder #(
    parameter int DATA_W = 16,
    parameter int RAM_AW = 8,
    parameter int LED_W  = 10,
    parameter int SW_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] dout,
    input  logic              w,
    output logic [DATA_W-1:0] din,
    input  logic [SW_W-1:0]   sw,
    output logic [LED_W-1:0]  ledr,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5,
    output logic              timer_irq
);

    localparam int RAM_D = 2 ** RAM_AW;

    logic [DATA_W-1:0] ram [RAM_D];
    logic [LED_W-1:0]  led_q;
    logic [6:0]        hex_q [6];
    logic [SW_W-1:0]   sw_s1;
    logic [SW_W-1:0]   sw_s2;
    logic [DATA_W-1:0] reload;
    logic [DATA_W-1:0] count;
    logic              en;
    logic              expired;

    logic [RAM_AW-1:0] ram_idx;
    logic              sel_ram, sel_led, sel_hex, sel_sw, sel_tmr;
    logic              wr_ram, wr_led, wr_hex, wr_cnt, wr_ctl;
    logic              fire;
    logic [6:0]        hex_rd;
    logic [DATA_W-1:0] rdata;
    logic              unused_addr;

    assign ram_idx = addr[RAM_AW-1:0];
    assign sel_ram = addr[15:12] == 4'h0;
    assign sel_led = addr[15:12] == 4'h1;
    assign sel_hex = addr[15:12] == 4'h2;
    assign sel_sw  = addr[15:12] == 4'h3;
    assign sel_tmr = addr[15:12] == 4'h4;

    assign wr_ram = w && sel_ram;
    assign wr_led = w && sel_led;
    assign wr_hex = w && sel_hex;
    assign wr_cnt = w && sel_tmr && !addr[0];
    assign wr_ctl = w && sel_tmr && addr[0];

    // Expiry only happens on a running timer not being reloaded by software
    assign fire = en && !wr_cnt && (count == '0);

    assign unused_addr = ^addr[11:RAM_AW];

    always_ff @(posedge clk) begin
        if (!reset && wr_ram) begin
            ram[ram_idx] <= dout;
        end
    end

    always_comb begin
        hex_rd = 7'h00;
        case (addr[2:0])
            3'd0: hex_rd = hex_q[0];
            3'd1: hex_rd = hex_q[1];
            3'd2: hex_rd = hex_q[2];
            3'd3: hex_rd = hex_q[3];
            3'd4: hex_rd = hex_q[4];
            3'd5: hex_rd = hex_q[5];
            default: hex_rd = 7'h00;
        endcase
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sel_ram: rdata = ram[ram_idx];
            sel_led: rdata = DATA_W'(led_q);
            sel_hex: rdata = DATA_W'(hex_rd);
            sel_sw:  rdata = DATA_W'(sw_s2);
            sel_tmr: rdata = addr[0] ? DATA_W'({expired, en}) : count;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            din   <= '0;
            led_q <= '0;
            sw_s1 <= '0;
            sw_s2 <= '0;
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= 7'h7F;
            end
        end else begin
            din   <= rdata;
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            if (wr_led) begin
                led_q <= dout[LED_W-1:0];
            end
            for (int i = 0; i < 6; i++) begin
                if (wr_hex && addr[2:0] == 3'(i)) begin
                    hex_q[i] <= dout[6:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reload  <= '0;
            count   <= '0;
            en      <= 1'b0;
            expired <= 1'b0;
        end else begin
            if (wr_cnt) begin
                reload <= dout;
                count  <= dout;
            end else if (en) begin
                count <= (count == '0) ? reload : count - DATA_W'(1);
            end
            if (wr_ctl) begin
                en <= dout[0];
                if (dout[1]) begin
                    expired <= 1'b0;
                end
            end
            // A clear landing on the expiry cycle loses to the new event
            if (fire) begin
                expired <= 1'b1;
            end
        end
    end

    assign ledr      = led_q;
    assign hex0      = hex_q[0];
    assign hex1      = hex_q[1];
    assign hex2      = hex_q[2];
    assign hex3      = hex_q[3];
    assign hex4      = hex_q[4];
    assign hex5      = hex_q[5];
    assign timer_irq = expired;

endmodule
